// File: rtl/powerup_spawner_if.sv
// Drop bus between the spawner, the shared LFSR block and the per-slot sprite controllers.
// The spawner is the master: it samples slot status and random values and issues spawn requests.
interface powerup_spawner_if #(
    parameter int N_CH   = 2,
    parameter int LFSR_W = 9,
    parameter int POS_W  = 10
);
    logic [N_CH-1:0]   slot_busy;
    logic [LFSR_W-1:0] lfsr_pos;
    logic [LFSR_W-1:0] lfsr_timer;
    logic [N_CH-1:0]   spawn;
    logic [POS_W-1:0]  spawn_pos;

    modport master (
        input  slot_busy,
        input  lfsr_pos,
        input  lfsr_timer,
        output spawn,
        output spawn_pos
    );

    modport slave (
        output slot_busy,
        output lfsr_pos,
        output lfsr_timer,
        input  spawn,
        input  spawn_pos
    );
endinterface

// File: rtl/powerup_spawner.sv
// Game-session FSM and power-up drop scheduler: latches difficulty, counts down pseudo-random
// drop intervals and hands each drop to the next free slot in round-robin order.
module powerup_spawner #(
    parameter int N_CH       = 2,
    parameter int LFSR_W     = 9,
    parameter int TIMER_W    = 10,
    parameter int POS_W      = 10,
    parameter int POS_OFFSET = 84,
    parameter int FIRST_DROP = 511,
    parameter int MIN_GAP    = 30
) (
    input  logic                     frame_clk,
    input  logic                     Reset,
    input  logic                     easy_selected,
    input  logic                     normal_selected,
    input  logic                     hard_selected,
    input  logic                     pause,
    input  logic                     game_over,
    powerup_spawner_if.master        drop_bus,
    output logic                     start_game,
    output logic [1:0]               difficulty,
    output logic [7:0]               missed_drops
);
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [1:0]         diff_q, diff_d;
    logic [N_CH-1:0]    spawn_q, spawn_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [7:0]         missed_q, missed_d;
    logic               start_q, start_d;
    logic               any_sel;
    logic               slot_found;
    logic [PTR_W-1:0]   slot_sel;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Harder levels shorten the interval, but never below the minimum gap.
    function automatic logic [TIMER_W-1:0] reload_val(input logic [LFSR_W-1:0] lt,
                                                      input logic [1:0] sh);
        logic [TIMER_W-1:0] r;
        r = TIMER_W'(lt) >> sh;
        return (r < TIMER_W'(MIN_GAP)) ? TIMER_W'(MIN_GAP) : r;
    endfunction

    assign any_sel = easy_selected | normal_selected | hard_selected;

    // Scanning from the farthest offset down leaves the nearest free slot in slot_sel.
    always_comb begin
        slot_found = 1'b0;
        slot_sel   = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (!drop_bus.slot_busy[(int'(ptr_q) + k) % N_CH]) begin
                slot_found = 1'b1;
                slot_sel   = PTR_W'((int'(ptr_q) + k) % N_CH);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        ptr_d    = ptr_q;
        diff_d   = diff_q;
        spawn_d  = '0;
        pos_d    = pos_q;
        missed_d = missed_q;
        unique case (state_q)
            IDLE: begin
                if (any_sel) begin
                    state_d  = RUN;
                    diff_d   = hard_selected ? 2'd2 : (normal_selected ? 2'd1 : 2'd0);
                    timer_d  = TIMER_W'(FIRST_DROP);
                    ptr_d    = '0;
                    missed_d = '0;
                end
            end
            RUN: begin
                if (game_over) begin
                    state_d = OVER;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    timer_d = reload_val(drop_bus.lfsr_timer, diff_q);
                    if (slot_found) begin
                        spawn_d = N_CH'(1) << slot_sel;
                        pos_d   = POS_W'(drop_bus.lfsr_pos) + POS_W'(POS_OFFSET);
                        ptr_d   = PTR_W'((int'(slot_sel) + 1) % N_CH);
                    end else begin
                        missed_d = sat_inc(missed_q);
                    end
                end
            end
            PAUSED: begin
                if (game_over)  state_d = OVER;
                else if (!pause) state_d = RUN;
            end
            OVER: begin
                // Wait for every button to be released so a held select cannot restart play.
                if (!game_over && !any_sel) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        start_d = (state_d == RUN) || (state_d == PAUSED);
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            ptr_q    <= '0;
            diff_q   <= '0;
            spawn_q  <= '0;
            pos_q    <= '0;
            missed_q <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ptr_q    <= ptr_d;
            diff_q   <= diff_d;
            spawn_q  <= spawn_d;
            pos_q    <= pos_d;
            missed_q <= missed_d;
            start_q  <= start_d;
        end
    end

    assign start_game         = start_q;
    assign difficulty         = diff_q;
    assign missed_drops       = missed_q;
    assign drop_bus.spawn     = spawn_q;
    assign drop_bus.spawn_pos = pos_q;
endmodule

// File: tb/tb_powerup_spawner.sv
// Directed walk through the session/drop scenarios followed by a random phase, every cycle
// compared against a session-level reference model.
module tb_powerup_spawner;
  localparam int N_CH       = 2;
  localparam int LFSR_W     = 9;
  localparam int POS_W      = 10;
  localparam int POS_OFFSET = 84;
  localparam int FIRST_DROP = 511;
  localparam int MIN_GAP    = 30;

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic       easy_selected = 1'b0, normal_selected = 1'b0, hard_selected = 1'b0;
  logic       pause = 1'b0, game_over = 1'b0;
  logic       start_game;
  logic [1:0] difficulty;
  logic [7:0] missed_drops;

  int n_pass = 0;
  int n_chk  = 0;

  // reference model: session flags, frames left until the next drop, next slot to try
  bit m_active, m_paused, m_over, m_start;
  int m_cnt, m_next, m_diff, m_missed, m_spawn, m_pos;

  always #5 frame_clk = ~frame_clk;

  powerup_spawner_if #(.N_CH(N_CH), .LFSR_W(LFSR_W), .POS_W(POS_W)) bus ();

  powerup_spawner #(
    .N_CH(N_CH), .LFSR_W(LFSR_W), .TIMER_W(10), .POS_W(POS_W),
    .POS_OFFSET(POS_OFFSET), .FIRST_DROP(FIRST_DROP), .MIN_GAP(MIN_GAP)
  ) dut (
    .frame_clk(frame_clk),
    .Reset(Reset),
    .easy_selected(easy_selected),
    .normal_selected(normal_selected),
    .hard_selected(hard_selected),
    .pause(pause),
    .game_over(game_over),
    .drop_bus(bus),
    .start_game(start_game),
    .difficulty(difficulty),
    .missed_drops(missed_drops)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_active = 0; m_paused = 0; m_over = 0; m_start = 0;
    m_cnt = 0; m_next = 0; m_diff = 0; m_missed = 0; m_spawn = 0; m_pos = 0;
  endtask

  task automatic model_drop();
    int r;
    int c;
    r = int'(bus.lfsr_timer) / (1 << m_diff);
    m_cnt = (r < MIN_GAP) ? MIN_GAP : r;
    c = -1;
    for (int k = 0; k < N_CH; k++)
      if (c < 0 && !bus.slot_busy[(m_next + k) % N_CH]) c = (m_next + k) % N_CH;
    if (c >= 0) begin
      m_spawn = 1 << c;
      m_pos   = (int'(bus.lfsr_pos) + POS_OFFSET) % (1 << POS_W);
      m_next  = (c + 1) % N_CH;
    end else if (m_missed < 255) begin
      m_missed++;
    end
  endtask

  task automatic model_step();
    bit any_sel;
    any_sel = easy_selected | normal_selected | hard_selected;
    m_spawn = 0;
    if (m_over) begin
      if (!game_over && !any_sel) m_over = 0;
    end else if (!m_active) begin
      if (any_sel) begin
        m_active = 1; m_paused = 0;
        m_diff   = hard_selected ? 2 : (normal_selected ? 1 : 0);
        m_cnt    = FIRST_DROP; m_next = 0; m_missed = 0;
      end
    end else if (game_over) begin
      m_active = 0; m_over = 1;
    end else if (m_paused) begin
      if (!pause) m_paused = 0;
    end else if (pause) begin
      m_paused = 1;
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else begin
      model_drop();
    end
    m_start = m_active;
  endtask

  task automatic compare_all();
    chk("start_game", int'(start_game), int'(m_start));
    chk("difficulty", int'(difficulty), m_diff);
    chk("spawn", int'(bus.spawn), m_spawn);
    chk("spawn_pos", int'(bus.spawn_pos), m_pos);
    chk("missed_drops", int'(missed_drops), m_missed);
  endtask

  task automatic tick();
    model_step();
    @(posedge frame_clk);
    #1;
    compare_all();
  endtask

  task automatic wait_spawn(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.spawn == '0 && n < budget);
    chk("spawn_seen", int'(bus.spawn != '0), 1);
  endtask

  task automatic end_session();
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    bus.slot_busy  = '0;
    bus.lfsr_pos   = 9'd100;
    bus.lfsr_timer = 9'd400;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_start_game", int'(start_game), 0);
    chk("rst_difficulty", int'(difficulty), 0);
    chk("rst_spawn", int'(bus.spawn), 0);
    chk("rst_spawn_pos", int'(bus.spawn_pos), 0);
    chk("rst_missed", int'(missed_drops), 0);
    tick();

    // basic drop on normal
    normal_selected = 1'b1;
    tick();
    normal_selected = 1'b0;
    chk("start_after_select", int'(start_game), 1);
    chk("diff_normal", int'(difficulty), 1);
    wait_spawn(600, n);
    chk("first_drop_gap", n, 512);
    chk("first_spawn_slot0", int'(bus.spawn), 1);
    chk("first_spawn_pos", int'(bus.spawn_pos), 184);
    wait_spawn(300, n);
    chk("gap_normal_400", n, 201);
    chk("spawn_round_robin", int'(bus.spawn), 2);
    end_session();

    // easy: full interval
    easy_selected = 1'b1;
    tick();
    easy_selected = 1'b0;
    chk("diff_easy", int'(difficulty), 0);
    wait_spawn(600, n);
    chk("first_drop_gap_easy", n, 512);
    wait_spawn(500, n);
    chk("gap_easy_400", n, 401);
    end_session();

    // hard: quarter interval, then floor at MIN_GAP
    hard_selected = 1'b1;
    tick();
    hard_selected = 1'b0;
    chk("diff_hard", int'(difficulty), 2);
    wait_spawn(600, n);
    wait_spawn(200, n);
    chk("gap_hard_400", n, 101);
    bus.lfsr_timer = 9'd40;
    wait_spawn(200, n);
    chk("gap_hard_400_b", n, 101);
    wait_spawn(200, n);
    chk("gap_hard_min", n, 31);

    // round robin: four spawns so far leave the pointer on slot 0
    bus.slot_busy = 2'b01;
    wait_spawn(40, n);
    chk("rr_skip_busy", int'(bus.spawn), 2);
    bus.slot_busy = 2'b00;
    wait_spawn(40, n);
    chk("rr_wrap", int'(bus.spawn), 1);
    bus.slot_busy = 2'b11;
    repeat (31) tick();
    chk("missed_one", int'(missed_drops), 1);
    repeat (300 * 31) tick();
    chk("missed_saturate", int'(missed_drops), 255);

    // pause with timer at 10: one cycle to leave PAUSED, then 11 RUN cycles
    bus.slot_busy = 2'b00;
    wait_spawn(40, n);
    repeat (20) tick();
    pause = 1'b1;
    repeat (50) tick();
    pause = 1'b0;
    wait_spawn(40, n);
    chk("pause_at_10", n, 12);

    // pause on the timer-zero cycle: drop on the first RUN cycle after resume
    repeat (30) tick();
    pause = 1'b1;
    repeat (5) tick();
    pause = 1'b0;
    wait_spawn(10, n);
    chk("pause_at_zero", n, 2);

    // game over on the drop cycle, held select keeps OVER
    repeat (30) tick();
    game_over = 1'b1;
    tick();
    chk("over_no_spawn", int'(bus.spawn), 0);
    chk("over_start_low", int'(start_game), 0);
    hard_selected = 1'b1;
    tick();
    game_over = 1'b0;
    repeat (3) tick();
    chk("over_held_select", int'(start_game), 0);
    hard_selected = 1'b0;
    tick();
    chk("idle_after_release", int'(start_game), 0);
    normal_selected = 1'b1;
    tick();
    normal_selected = 1'b0;
    chk("restart_start", int'(start_game), 1);
    chk("restart_missed_clear", int'(missed_drops), 0);

    // random phase
    for (int i = 0; i < 5000; i++) begin
      bus.slot_busy   = 2'($urandom);
      bus.lfsr_pos    = 9'($urandom);
      bus.lfsr_timer  = 9'($urandom);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      game_over       = ($urandom_range(0, 399) == 0);
      easy_selected   = ($urandom_range(0, 49) == 0);
      normal_selected = ($urandom_range(0, 49) == 0);
      hard_selected   = ($urandom_range(0, 49) == 0);
      tick();
    end
    {pause, game_over, easy_selected, normal_selected, hard_selected} = '0;
    bus.slot_busy  = '0;
    bus.lfsr_pos   = 9'd100;
    bus.lfsr_timer = 9'd400;
    end_session();

    // asynchronous reset while a spawn pulse is on the bus
    normal_selected = 1'b1;
    tick();
    normal_selected = 1'b0;
    wait_spawn(600, n);
    #2;
    Reset = 1'b1;
    #1;
    chk("async_start_game", int'(start_game), 0);
    chk("async_difficulty", int'(difficulty), 0);
    chk("async_spawn", int'(bus.spawn), 0);
    chk("async_spawn_pos", int'(bus.spawn_pos), 0);
    chk("async_missed", int'(missed_drops), 0);
    model_reset();
    @(posedge frame_clk);
    #1;
    Reset = 1'b0;
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/powerup_spawner.md
# powerup_spawner

Game-session and power-up drop controller for the final project, clocked on the frame clock. It starts a session when a difficulty is selected and latches that difficulty. It then schedules power-up drops at pseudo-random intervals and start positions across `N_CH` independent power-up slots, with pause and game-over handling. It sits between the menu/difficulty logic, the shared LFSR block, and the per-slot power-up sprite controllers.

## Interface

Parameters:
- `N_CH`, 2: number of power-up slots (1–8).
- `LFSR_W`, 9: width of the LFSR inputs.
- `TIMER_W`, 10: drop-timer width; must be ≥ `LFSR_W`.
- `POS_W`, 10: spawn-position width.
- `POS_OFFSET`, 84: added to the random position (playfield left edge).
- `FIRST_DROP`, 511: timer load value on session start.
- `MIN_GAP`, 30: minimum reload interval in frames.

Ports:
- `frame_clk`  in  1: frame clock; all logic on its rising edge.
- `Reset`  in  1: asynchronous, active-high reset.
- `easy_selected`, `normal_selected`, `hard_selected`  in  1 each: menu selects.
- `pause`  in  1: level; freezes the session while high.
- `game_over`  in  1: ends the session.
- `slot_busy`  in  `N_CH`: bit i high while power-up i is on screen.
- `lfsr_pos`  in  `LFSR_W`: random start position.
- `lfsr_timer`  in  `LFSR_W`: random drop interval.
- `start_game`  out  1: high in RUN and PAUSED.
- `difficulty`  out  2: 0 = easy, 1 = normal, 2 = hard.
- `spawn`  out  `N_CH`: one-hot, one-cycle pulse requesting slot i to spawn.
- `spawn_pos`  out  `POS_W`: start position, valid with `spawn` and held until the next spawn.
- `missed_drops`  out  8: saturating count of drops lost because all slots were busy.

## Operation

- FSM states: IDLE, RUN, PAUSED, OVER.
- **IDLE → RUN** when any select is high.
  - `difficulty` is latched with priority hard > normal > easy.
  - The timer is loaded with `FIRST_DROP`.
  - The round-robin pointer is cleared to 0.
- **RUN → PAUSED** when `pause` is high. **PAUSED → RUN** when `pause` is low.
- **RUN or PAUSED → OVER** when `game_over` is high. `game_over` has priority over `pause` and over drops.
- **OVER → IDLE** when `game_over` is low and all selects are low. A held button must not restart the game.
- In RUN with timer ≠ 0: the timer decrements by 1.
- In RUN with timer = 0, a drop event occurs:
  - Reload the timer with `R = zext(lfsr_timer) >> difficulty`, i.e. shift 0, 1 or 2. If `R < MIN_GAP`, load `MIN_GAP` instead.
  - Select the first slot with `slot_busy` low, searching from the pointer upward with wrap modulo `N_CH`.
  - If a slot c is found: pulse `spawn[c]`, set `spawn_pos = zext(lfsr_pos) + POS_OFFSET` modulo 2^`POS_W`, and set the pointer to (c+1) mod `N_CH`.
  - If all slots are busy: no pulse, the pointer is unchanged, and `missed_drops` increments, saturating at 255.
- In PAUSED, IDLE and OVER the timer is frozen and `spawn` is 0.
- `difficulty`, `missed_drops` and `spawn_pos` hold through OVER. They are updated or cleared only on the next IDLE → RUN transition, where `missed_drops` clears to 0.

## Timing

- **Reset values:** state IDLE, `start_game` 0, `difficulty` 0, `spawn` 0, `spawn_pos` 0, `missed_drops` 0, timer 0, pointer 0.
- **Reset mid-session:** the FSM returns to IDLE immediately and any in-flight `spawn` pulse is cleared.
- **Output registration:** all outputs are registered.
  - `start_game` rises in the cycle after the select is sampled.
  - `spawn` and `spawn_pos` appear in the cycle after the timer is sampled at 0.
- **Drop spacing:** the first drop occurs `FIRST_DROP`+1 RUN cycles after entering RUN. Subsequent drops occur reload+1 RUN cycles apart; PAUSED cycles do not count.
- **`pause` coincident with timer = 0:** pause wins. The timer holds 0 and the drop fires on the first RUN cycle after resume.
- **`game_over` coincident with a drop:** no spawn, no miss count.
- **`slot_busy`** is sampled in the drop cycle only.
- **Multiple selects in the same cycle:** resolved by the priority above.

## Test plan

- **Basic drop:** press `normal_selected` 1 cycle with `FIRST_DROP`=511, `lfsr_pos`=100, slots free. Expect `start_game`=1 next cycle, `difficulty`=1, `spawn`=01 exactly 512 cycles later, `spawn_pos`=184.
- **Reload per difficulty:** `lfsr_timer`=400. Expect reload 400 (easy), 200 (normal), 100 (hard). With `lfsr_timer`=40 on hard, expect reload `MIN_GAP`=30.
- **Round-robin and misses:** `N_CH`=2.
  - Slot 0 busy → `spawn`=10.
  - Next drop with all slots free → `spawn`=01 (pointer wrapped).
  - Both busy → no pulse, `missed_drops`=1.
  - Force 300 misses → `missed_drops` saturates at 255.
- **Pause:** assert `pause` 50 cycles when the timer is at 10. Expect no spawn during the pause and the spawn exactly 11 RUN cycles after release. Also assert pause on the timer-zero cycle and expect the spawn on the first cycle after resume.
- **Game over:** assert `game_over` on the drop cycle. Expect no spawn and `start_game` low next cycle. Holding `hard_selected` keeps the FSM in OVER; releasing everything returns it to IDLE.
- **Async reset:** assert `Reset` mid-RUN between clock edges. Expect all outputs at reset values immediately, without waiting for a clock edge.
